// File: rtl/seq_data_dependency_unit.sv
// Stateful operand-forwarding and load-use hazard unit.
// Keeps a short shift register with the destinations of in-flight
// instructions. For each READ operand it picks the youngest in-flight
// producer to forward from. When the producer in EXECUTE is a load, it
// requests a one-cycle stall and inserts a bubble instead.
module seq_data_dependency_unit #(
  parameter int REG_ADDR_W  = 3,
  parameter int STAGES      = 2,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issue_valid,
  input  logic                  i_src1_valid,
  input  logic [REG_ADDR_W-1:0] i_src1,
  input  logic                  i_src2_valid,
  input  logic [REG_ADDR_W-1:0] i_src2,
  input  logic                  i_dst_valid,
  input  logic [REG_ADDR_W-1:0] i_dst,
  input  logic                  i_dst_is_load,
  input  logic                  i_flush,
  input  logic                  i_stall_ext,
  output logic [SEL_W-1:0]      o_fwd_sel1,
  output logic [SEL_W-1:0]      o_fwd_sel2,
  output logic                  o_stall,
  output logic [CNT_W-1:0]      o_stall_count
);

  // Tracker entries: index 0 is the instruction now in EXECUTE, higher indices are older.
  logic [STAGES-1:0]     validQ, validD;
  logic [STAGES-1:0]     loadQ, loadD;
  logic [REG_ADDR_W-1:0] dstQ [STAGES];
  logic [REG_ADDR_W-1:0] dstD [STAGES];
  logic [CNT_W-1:0]      cntQ, cntD;

  logic                  src1Live, src2Live;
  logic [STAGES-1:0]     match1, match2;
  logic [SEL_W-1:0]      sel1Raw, sel2Raw;
  logic                  loadUse;

  // Qualify each operand and compare it against every in-flight destination.
  always_comb begin
    src1Live = i_issue_valid & i_src1_valid &
               ~((ZERO_REG_EN != 0) && (i_src1 == '0));
    src2Live = i_issue_valid & i_src2_valid &
               ~((ZERO_REG_EN != 0) && (i_src2 == '0));
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < STAGES; k++) begin
      match1[k] = src1Live & validQ[k] & (dstQ[k] == i_src1);
      match2[k] = src2Live & validQ[k] & (dstQ[k] == i_src2);
    end
  end

  // Pick the youngest matching producer; scanning oldest-first lets the youngest overwrite.
  always_comb begin
    sel1Raw = '0;
    sel2Raw = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (match1[k]) sel1Raw = SEL_W'(k + 1);
      if (match2[k]) sel2Raw = SEL_W'(k + 1);
    end
  end

  // A load still in EXECUTE cannot forward yet, so stall and suppress both selects.
  always_comb begin
    loadUse       = (match1[0] | match2[0]) & loadQ[0] & ~i_rst;
    o_stall       = loadUse;
    o_fwd_sel1    = (loadUse | i_rst) ? '0 : sel1Raw;
    o_fwd_sel2    = (loadUse | i_rst) ? '0 : sel2Raw;
    o_stall_count = cntQ;
  end

  // Tracker next state: a flush empties the tracker, an external freeze holds it, and otherwise it shifts.
  always_comb begin
    validD = validQ;
    loadD  = loadQ;
    dstD   = dstQ;
    if (i_flush) begin
      validD = '0;
    end else if (!i_stall_ext) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        validD[k] = validQ[k-1];
        loadD[k]  = loadQ[k-1];
        dstD[k]   = dstQ[k-1];
      end
      if (loadUse) begin
        validD[0] = 1'b0;
        loadD[0]  = 1'b0;
      end else begin
        validD[0] = i_issue_valid & i_dst_valid;
        loadD[0]  = i_dst_is_load;
        dstD[0]   = i_dst;
      end
    end
  end

  // Count stall cycles that actually take effect, saturating at all-ones.
  always_comb begin
    cntD = cntQ;
    if (loadUse && !i_flush && !i_stall_ext && (cntQ != '1)) begin
      cntD = cntQ + CNT_W'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      validQ <= '0;
      loadQ  <= '0;
      for (int k = 0; k < STAGES; k++) dstQ[k] <= '0;
      cntQ   <= '0;
    end else begin
      validQ <= validD;
      loadQ  <= loadD;
      dstQ   <= dstD;
      cntQ   <= cntD;
    end
  end

endmodule
